nonce_scanner: RTL and testbench
================================

# nonce_scanner

Job sequencer directly upstream of `sha256_2_pipeline`, also consuming its output. Latches one mining job (midstate, 96-bit header tail, nonce range, target) and issues one 128-bit block per cycle with an incrementing nonce. It matches each returned digest to its nonce by in-order counting and compares it against the target. Winning nonces are buffered in a small hit FIFO for the host.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: hit FIFO entries; power of two, ≥2.
- `OUT_W`, default 8: width of the in-flight counter; pipeline depth must be < 2^OUT_W.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `start` in 1: latch job and begin sweep; ignored while `busy`.
- `stop` in 1: abort issuing; in-flight results still drained.
- `midstate_in` in 256: midstate for the job.
- `tail_in` in 96: {merkle_tail, ntime, nbits}.
- `nonce_start` in 32: first nonce, inclusive.
- `nonce_end` in 32: last nonce, inclusive.
- `target_in` in 256: unsigned hit threshold.
- `pipe_write_en` out 1: drives pipeline `write_en`.
- `pipe_digest_initial` out 256: drives `digest_intial`; latched midstate.
- `pipe_digest` out 256: drives `digest_in`; latched midstate.
- `pipe_block` out 128: drives `block_in` = {tail, nonce}, nonce in [31:0].
- `pipe_result` in 256: from pipeline `digest_out`.
- `pipe_valid` in 1: from pipeline `valid_out`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at job end.
- `hit_valid` out 1: FIFO non-empty.
- `hit_nonce` out 32: FIFO head.
- `hit_ready` in 1: pop when `hit_valid` is also high.
- `hit_overflow` out 1: sticky; a hit was dropped because the FIFO was full. Cleared on `start`.

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE + `start`:
  - latch midstate, tail, `nonce_end` and target;
  - `issue_nonce` = `res_nonce` = `nonce_start`;
  - clear `hit_overflow`;
  - go to SWEEP.
- SWEEP: every cycle `pipe_write_en`=1 and `pipe_block` = {tail, `issue_nonce`}; then `issue_nonce`++ and in-flight++.
  - If the issued nonce == `nonce_end`, or `stop` is high, go to DRAIN.
  - With `stop`, the nonce on the bus that cycle is still issued.
- Nonce arithmetic is modulo 2^32. `nonce_end` < `nonce_start` wraps through 0xFFFFFFFF.
- DRAIN: `pipe_write_en`=0. Go to DONE when in-flight == 0 and the compare stage is empty.
- DONE: `done`=1 for one cycle, then IDLE.
- On `pipe_valid` in SWEEP or DRAIN:
  - in-flight--;
  - compare stage registers (`pipe_result` <= target, `res_nonce`);
  - `res_nonce`++.
- In IDLE or DONE, `pipe_valid` is ignored.
- Simultaneous issue and return in one cycle: in-flight unchanged.
- Compare stage pushes `res_nonce` into the FIFO when the compare result is true.
  - FIFO full with no pop that cycle: drop the hit, set `hit_overflow`.
  - Full with a pop in the same cycle: push accepted.
- FIFO contents persist across jobs. `start` does not flush it.
- `stop` outside SWEEP: no effect.
- Reset state: `pipe_write_en`=0, `pipe_block`/`pipe_digest`/`pipe_digest_initial`=0, `busy`=0, `done`=0, `hit_valid`=0, `hit_nonce`=0, `hit_overflow`=0, FIFO empty, counters 0, state IDLE.

## Timing
- `start` sampled at edge 0 → `pipe_write_en`=1 with `nonce_start` in the cycle after edge 0.
- Throughput: one nonce per cycle. N nonces produce exactly N consecutive `pipe_write_en` cycles.
- `pipe_valid` at edge t → compare registered at t+1 → `hit_valid` high after edge t+2 when the FIFO was empty.
- `done` asserts two cycles after the edge that consumes the last `pipe_valid`.
- `RST` low at any point clears all state immediately (asynchronous), including mid-SWEEP and mid-DRAIN.

## Configuration
- `NONCE_BSWAP_EN`
  - Defined: the nonce placed in `pipe_block[31:0]` is byte-swapped, so 0x00000011 appears as 0x11000000. `hit_nonce` still reports the unswapped counter value.
  - Undefined: nonce inserted as-is.

## Structure
- Shared package `scan_pkg`: state enum, `NONCE_W`=32, `TAIL_W`=96, `BLOCK_W`=128, `DIGEST_W`=256.
- Sub-module `scan_hit_fifo`: synchronous FIFO, `FIFO_DEPTH` × 32, with push/pop/full/empty.

## Test plan
- Midstate 583B37603E3276CB065F1DE4360714E305874C8EC03AF63C381792750278F397, tail 0, start = end = 0x00000011, target all-ones → one write with block 0x…0011, one hit nonce 0x11, `done` pulse.
- Range 0x0–0xF, target 0 → 16 consecutive writes, nonces 0..15, no hits, in-flight returns to 0, `done`.
- start 0xFFFFFFFE, end 0x00000001 → four writes in order FFFFFFFE, FFFFFFFF, 00000000, 00000001; then DRAIN.
- `FIFO_DEPTH`=4, target all-ones, `hit_ready`=0, 8 nonces from 0x100 → `hit_overflow`=1; pops return 0x100–0x103, then `hit_valid`=0.
- `stop` pulsed on the 5th write cycle of range 0–99, plus `start` asserted again → exactly 5 writes, `done` after 5 valids, second `start` ignored.
- `RST` low during DRAIN with 10 in flight → all outputs at reset values asynchronously; stray `pipe_valid` afterwards produces no hit.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the nonce scanner and its hit FIFO.
package scan_pkg;

  localparam int NONCE_W  = 32;
  localparam int TAIL_W   = 96;
  localparam int BLOCK_W  = 128;
  localparam int DIGEST_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  // Reverse the byte order of a nonce (little-endian header field).
  function automatic logic [NONCE_W-1:0] bswap32(input logic [NONCE_W-1:0] n);
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
  endfunction

endpackage

// File: rtl/scan_hit_fifo.sv
// Synchronous FIFO holding winning nonces until the host pops them.
// A push while full is accepted only if a pop happens in the same cycle.
module scan_hit_fifo
  import scan_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [NONCE_W-1:0] data_i,
  input  logic               pop_i,
  output logic [NONCE_W-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NONCE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q;
  logic [AW:0]        rd_ptr_q;
  logic               do_push;
  logic               do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is forced to zero when empty so the host never sees stale data.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; empty pointers already make its contents unobservable.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/nonce_scanner.sv
// Mining job sequencer: feeds sha256_2_pipeline one block per cycle with an
// incrementing nonce, matches returned digests to nonces by in-order
// counting, compares against the target and queues winners in a hit FIFO.
// Optional build macro NONCE_BSWAP_EN: byte-swap the nonce placed in the
// block (hit_nonce still reports the unswapped counter).
module nonce_scanner
  import scan_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_W      = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                stop,
  input  logic [DIGEST_W-1:0] midstate_in,
  input  logic [TAIL_W-1:0]   tail_in,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [NONCE_W-1:0]  nonce_end,
  input  logic [DIGEST_W-1:0] target_in,
  output logic                pipe_write_en,
  output logic [DIGEST_W-1:0] pipe_digest_initial,
  output logic [DIGEST_W-1:0] pipe_digest,
  output logic [BLOCK_W-1:0]  pipe_block,
  input  logic [DIGEST_W-1:0] pipe_result,
  input  logic                pipe_valid,
  output logic                busy,
  output logic                done,
  output logic                hit_valid,
  output logic [NONCE_W-1:0]  hit_nonce,
  input  logic                hit_ready,
  output logic                hit_overflow
);

  scan_state_e         state_q;
  logic [DIGEST_W-1:0] mid_q;
  logic [TAIL_W-1:0]   tail_q;
  logic [NONCE_W-1:0]  end_q;
  logic [DIGEST_W-1:0] target_q;
  logic [NONCE_W-1:0]  issue_nonce_q;
  logic [NONCE_W-1:0]  res_nonce_q;
  logic [OUT_W-1:0]    inflight_q;
  logic [OUT_W-1:0]    inflight_d;
  logic                write_en_q;
  logic                done_q;
  logic                overflow_q;
  logic                cmp_valid_q;
  logic                cmp_hit_q;
  logic [NONCE_W-1:0]  cmp_nonce_q;

  logic                job_start;
  logic                issue;
  logic                ret;
  logic                hit_push;
  logic                hit_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [NONCE_W-1:0]  block_nonce;

  assign job_start = (state_q == ST_IDLE) && start;
  assign issue     = write_en_q;
  // Returns only count while a job is active; stray valids elsewhere are ignored.
  assign ret       = pipe_valid && ((state_q == ST_SWEEP) || (state_q == ST_DRAIN));
  assign hit_push  = cmp_valid_q && cmp_hit_q;
  assign hit_pop   = hit_ready && hit_valid;

  // Simultaneous issue and return cancel out.
  assign inflight_d = inflight_q + {{(OUT_W-1){1'b0}}, issue}
                                 - {{(OUT_W-1){1'b0}}, ret};

`ifdef NONCE_BSWAP_EN
  assign block_nonce = bswap32(issue_nonce_q);
`else
  assign block_nonce = issue_nonce_q;
`endif

  assign pipe_write_en       = write_en_q;
  assign pipe_digest_initial = mid_q;
  assign pipe_digest         = mid_q;
  assign pipe_block          = {tail_q, block_nonce};
  assign busy                = (state_q != ST_IDLE);
  assign done                = done_q;
  assign hit_overflow        = overflow_q;
  assign hit_valid           = !fifo_empty;

  // Job FSM: latches the job, sweeps the nonce range, waits for drain, pulses done.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      mid_q         <= '0;
      tail_q        <= '0;
      end_q         <= '0;
      target_q      <= '0;
      issue_nonce_q <= '0;
      write_en_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mid_q         <= midstate_in;
            tail_q        <= tail_in;
            end_q         <= nonce_end;
            target_q      <= target_in;
            issue_nonce_q <= nonce_start;
            write_en_q    <= 1'b1;
            state_q       <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          // The nonce on the bus this cycle is issued even when stopping.
          issue_nonce_q <= issue_nonce_q + 1'b1;
          if ((issue_nonce_q == end_q) || stop) begin
            write_en_q <= 1'b0;
            state_q    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((inflight_q == '0) && !cmp_valid_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // In-flight counting and the registered target compare for each returned digest.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      inflight_q  <= '0;
      res_nonce_q <= '0;
      cmp_valid_q <= 1'b0;
      cmp_hit_q   <= 1'b0;
      cmp_nonce_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (job_start) begin
        res_nonce_q <= nonce_start;
      end else if (ret) begin
        res_nonce_q <= res_nonce_q + 1'b1;
      end
      cmp_valid_q <= ret;
      if (ret) begin
        cmp_hit_q   <= (pipe_result <= target_q);
        cmp_nonce_q <= res_nonce_q;
      end
    end
  end

  // Sticky overflow flag: set when a hit is dropped, cleared by a new job.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overflow_q <= 1'b0;
    end else if (job_start) begin
      overflow_q <= 1'b0;
    end else if (hit_push && fifo_full && !hit_pop) begin
      overflow_q <= 1'b1;
    end
  end

  scan_hit_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_hit_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .push_i  (hit_push),
    .data_i  (cmp_nonce_q),
    .pop_i   (hit_pop),
    .data_o  (hit_nonce),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_nonce_scanner.sv
// Scoreboard bench for nonce_scanner with a behavioural fixed-latency
// pipeline. Expected blocks and hits are queued by the stimulus and popped
// by independent monitors whenever the DUT presents them.
module tb_nonce_scanner;

  localparam int PIPE_LAT = 12;
  localparam logic [255:0] MIDSTATE =
    256'h583B37603E3276CB065F1DE4360714E305874C8EC03AF63C381792750278F397;
  localparam logic [255:0] ALL_ONES = {256{1'b1}};

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [255:0] midstate_in = '0;
  logic [95:0]  tail_in = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic [255:0] target_in = '0;
  logic         pipe_write_en;
  logic [255:0] pipe_digest_initial;
  logic [255:0] pipe_digest;
  logic [127:0] pipe_block;
  logic [255:0] pipe_result = '0;
  logic         pipe_valid = 1'b0;
  logic         busy;
  logic         done;
  logic         hit_valid;
  logic [31:0]  hit_nonce;
  logic         hit_ready = 1'b1;
  logic         hit_overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_valid_cyc = 0;
  bit flush_req = 1'b0;
  bit stray_req = 1'b0;

  logic [127:0] exp_blk_q [$];
  logic [31:0]  exp_hit_q [$];

  nonce_scanner #(
    .FIFO_DEPTH (4),
    .OUT_W      (8)
  ) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .start               (start),
    .stop                (stop),
    .midstate_in         (midstate_in),
    .tail_in             (tail_in),
    .nonce_start         (nonce_start),
    .nonce_end           (nonce_end),
    .target_in           (target_in),
    .pipe_write_en       (pipe_write_en),
    .pipe_digest_initial (pipe_digest_initial),
    .pipe_digest         (pipe_digest),
    .pipe_block          (pipe_block),
    .pipe_result         (pipe_result),
    .pipe_valid          (pipe_valid),
    .busy                (busy),
    .done                (done),
    .hit_valid           (hit_valid),
    .hit_nonce           (hit_nonce),
    .hit_ready           (hit_ready),
    .hit_overflow        (hit_overflow)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Nonce as it should appear in the low word of the block.
  function automatic logic [31:0] field_of(input logic [31:0] n);
`ifdef NONCE_BSWAP_EN
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
    return n;
`endif
  endfunction

  // Fake digest for a nonce: 2^32 + nonce (never zero).
  function automatic logic [255:0] digest_of(input logic [31:0] n);
    return {192'h0, 32'h1, n};
  endfunction

  // Behavioural pipeline: returns one digest per issued block after PIPE_LAT cycles.
  initial begin : pipe_model
    logic        line_v [PIPE_LAT];
    logic [31:0] line_n [PIPE_LAT];
    for (int i = 0; i < PIPE_LAT; i++) begin
      line_v[i] = 1'b0;
      line_n[i] = '0;
    end
    forever begin
      @(negedge CLK);
      if (flush_req) begin
        for (int i = 0; i < PIPE_LAT; i++) line_v[i] = 1'b0;
        pipe_valid = 1'b0;
      end else begin
        pipe_valid  = line_v[0];
        pipe_result = digest_of(line_n[0]);
        for (int i = 0; i < PIPE_LAT-1; i++) begin
          line_v[i] = line_v[i+1];
          line_n[i] = line_n[i+1];
        end
        line_v[PIPE_LAT-1] = RST && pipe_write_en;
        line_n[PIPE_LAT-1] = field_of(pipe_block[31:0]);
      end
      if (stray_req) begin
        pipe_valid  = 1'b1;
        pipe_result = '0;
      end
      if (pipe_valid) last_valid_cyc = cyc + 1;
    end
  end

  // Write monitor: every issued block must match the next expected one.
  initial forever begin
    @(negedge CLK);
    if (RST && pipe_write_en) begin
      if (exp_blk_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got block %0h expected no write", pipe_block);
      end else begin
        check("write_block", {128'h0, pipe_block}, {128'h0, exp_blk_q.pop_front()});
      end
    end
  end

  // Hit monitor: every popped hit must match the next expected nonce.
  initial forever begin
    @(negedge CLK);
    if (RST && hit_valid && hit_ready) begin
      if (exp_hit_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_hit: got nonce %0h expected none", hit_nonce);
      end else begin
        check("hit_nonce", {224'h0, hit_nonce}, {224'h0, exp_hit_q.pop_front()});
      end
    end
  end

  // Done monitor: counts pulses and checks the two-cycle drain latency.
  initial forever begin
    @(negedge CLK);
    if (RST && done) begin
      done_cnt++;
      check("done_latency", 256'(cyc), 256'(last_valid_cyc + 2));
    end
  end

  // Issue a job at posedge+1 and queue the blocks expected from it.
  task automatic start_job(input logic [31:0] ns, input logic [31:0] ne,
                           input logic [255:0] tgt, input logic [95:0] tail,
                           input int n_exp);
    logic [31:0] n;
    n = ns;
    for (int i = 0; i < n_exp; i++) begin
      exp_blk_q.push_back({tail, field_of(n)});
      n = n + 32'd1;
    end
    midstate_in = MIDSTATE;
    tail_in     = tail;
    nonce_start = ns;
    nonce_end   = ne;
    target_in   = tgt;
    start       = 1'b1;
    @(posedge CLK);
    #1;
    start       = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt, input string name);
    int n;
    n = 0;
    while (done_cnt < exp_cnt && n < 2000) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check(name, 256'(done_cnt), 256'(exp_cnt));
    check({name, "_writes_left"}, 256'(exp_blk_q.size()), 256'd0);
  endtask

  task automatic drain_hits(input string name);
    int n;
    n = 0;
    while (exp_hit_q.size() != 0 && n < 50) begin
      @(posedge CLK);
      n++;
    end
    repeat (2) @(posedge CLK);
    #1;
    check({name, "_hits_left"}, 256'(exp_hit_q.size()), 256'd0);
    check({name, "_hit_valid"}, {255'h0, hit_valid}, 256'd0);
  endtask

  initial begin : stimulus
    int n;
    repeat (3) @(posedge CLK);
    #1;
    // Reset values while held in reset.
    check("rst_write_en", {255'h0, pipe_write_en}, 256'd0);
    check("rst_block", {128'h0, pipe_block}, 256'd0);
    check("rst_digest", pipe_digest, 256'd0);
    check("rst_busy", {255'h0, busy}, 256'd0);
    check("rst_hit_valid", {255'h0, hit_valid}, 256'd0);
    check("rst_hit_nonce", {224'h0, hit_nonce}, 256'd0);
    check("rst_overflow", {255'h0, hit_overflow}, 256'd0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Single nonce 0x11, target all-ones: one write, one hit.
    exp_hit_q.push_back(32'h11);
    start_job(32'h11, 32'h11, ALL_ONES, 96'h0, 1);
    check("t1_first_write_en", {255'h0, pipe_write_en}, 256'd1);
    check("t1_first_block", {128'h0, pipe_block}, {128'h0, 96'h0, field_of(32'h11)});
    check("t1_digest_initial", pipe_digest_initial, MIDSTATE);
    check("t1_busy", {255'h0, busy}, 256'd1);
    wait_done(1, "t1_done");
    drain_hits("t1");

    // Range 0..15, target 0: 16 writes, no hits.
    start_job(32'h0, 32'hF, 256'h0, 96'hCAFEF00D_12345678_9ABCDEF0, 16);
    wait_done(2, "t2_done");
    drain_hits("t2");

    // Wrap through 0xFFFFFFFF.
    start_job(32'hFFFFFFFE, 32'h00000001, 256'h0, 96'h0, 4);
    wait_done(3, "t3_done");
    drain_hits("t3");

    // Target boundary: digest == target is a hit; nonces 0..3 hit, 4..7 miss.
    for (int i = 0; i < 4; i++) exp_hit_q.push_back(32'(i));
    start_job(32'h0, 32'h7, {192'h0, 32'h1, 32'h3}, 96'h0, 8);
    wait_done(4, "t4_done");
    drain_hits("t4");

    // Overflow: host not popping, 8 hits into a 4-deep FIFO.
    hit_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_hit_q.push_back(32'h100 + 32'(i));
    start_job(32'h100, 32'h107, ALL_ONES, 96'h0, 8);
    wait_done(5, "t5_done");
    check("t5_overflow", {255'h0, hit_overflow}, 256'd1);
    check("t5_hit_valid", {255'h0, hit_valid}, 256'd1);
    check("t5_head", {224'h0, hit_nonce}, 256'h100);
    hit_ready = 1'b1;
    drain_hits("t5");

    // Stop on the 5th write, with a second start that must be ignored.
    start_job(32'h0, 32'd99, 256'h0, 96'h0, 5);
    check("t6_overflow_cleared", {255'h0, hit_overflow}, 256'd0);
    repeat (4) @(posedge CLK);
    #1;
    stop  = 1'b1;
    start = 1'b1;
    @(posedge CLK);
    #1;
    stop  = 1'b0;
    start = 1'b0;
    wait_done(6, "t6_done");
    repeat (3) @(posedge CLK);
    #1;
    check("t6_no_restart", {255'h0, busy}, 256'd0);

    // Asynchronous reset during DRAIN with 10 in flight.
    hit_ready = 1'b0;
    start_job(32'h200, 32'h209, ALL_ONES, 96'h0, 10);
    n = 0;
    while (!(busy && !pipe_write_en) && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("t7_in_drain", {255'h0, busy && !pipe_write_en}, 256'd1);
    #2;
    RST = 1'b0;
    flush_req = 1'b1;
    #1;
    check("t7_rst_busy", {255'h0, busy}, 256'd0);
    check("t7_rst_block", {128'h0, pipe_block}, 256'd0);
    check("t7_rst_digest_init", pipe_digest_initial, 256'd0);
    check("t7_rst_done", {255'h0, done}, 256'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    flush_req = 1'b0;
    stray_req = 1'b1;
    @(posedge CLK);
    #1;
    stray_req = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("t7_stray_no_hit", {255'h0, hit_valid}, 256'd0);
    check("t7_no_done", 256'(done_cnt), 256'd6);
    check("t7_no_write", {255'h0, pipe_write_en}, 256'd0);
    hit_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
